// File: rtl/lcd_power_seq.sv
// Power-up / reconfiguration sequencer for the RGB LCD timing driver: ID latch, driver reset,
// frame settle, backlight PWM ramp, vsync watchdog. Define LCD_SEQ_BL_RAMP_EN for a stepped ramp.
module lcd_power_seq #(
    parameter int unsigned  RST_CYCLES    = 1000,
    parameter int unsigned  SETTLE_FRAMES = 2,
    parameter logic [7:0]   BL_MAX        = 8'd200,
    parameter logic [7:0]   BL_STEP       = 8'd8,
    parameter logic [23:0]  TIMEOUT       = 24'd2_000_000
) (
    input  logic        lcd_clk,
    input  logic        sys_rst_n,
    input  logic [15:0] id_raw,
    input  logic        id_valid,
    input  logic        lcd_vs,
    output logic [15:0] ID_lcd,
    output logic        drv_rst_n,
    output logic        bl_pwm,
    output logic        ready,
    output logic        fault,
    output logic        id_unsup
);

    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int FRM_W = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES) : 1;
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(SETTLE_FRAMES - 1);
    localparam logic [23:0]      TO_LAST  = TIMEOUT - 24'd1;

`ifdef LCD_SEQ_BL_RAMP_EN
    localparam logic [7:0] RAMP_INC = BL_STEP;
`else
    // Jumping by BL_MAX from zero saturates in one frame; BL_STEP plays no part here.
    localparam logic [7:0] RAMP_INC = BL_MAX;
    logic unused_bl_step;
    assign unused_bl_step = ^BL_STEP;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRV_RESET,
        S_WAIT_FRAMES,
        S_BL_RAMP,
        S_RUN,
        S_FAULT
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        id_q, id_d;
    logic               unsup_q, unsup_d;
    logic [7:0]         duty_q, duty_d;
    logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [FRM_W-1:0]   frm_cnt_q, frm_cnt_d;
    logic [23:0]        to_cnt_q, to_cnt_d;
    logic               vs_d_q, idv_d_q;
    logic [7:0]         pwm_cnt_q;
    logic               bl_pwm_q, drv_rst_n_q, ready_q, fault_q;

    logic               vs_rise, idv_rise, state_chg, id_ok;
    logic [15:0]        id_map;

    function automatic logic id_supported(input logic [15:0] raw);
        case (raw)
            16'd0, 16'd1, 16'd2, 16'd5: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, BL_MAX}) ? BL_MAX : sum[7:0];
    endfunction

    assign vs_rise  = lcd_vs & ~vs_d_q;
    assign idv_rise = id_valid & ~idv_d_q;
    assign id_ok    = id_supported(id_raw);
    assign id_map   = id_ok ? id_raw : 16'd0;

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        unsup_d = unsup_q;
        duty_d  = duty_q;
        case (state_q)
            S_IDLE: begin
                duty_d = 8'd0;
                if (id_valid) begin
                    id_d    = id_map;
                    unsup_d = ~id_ok;
                    state_d = S_DRV_RESET;
                end
            end
            S_DRV_RESET: begin
                if (rst_cnt_q == RST_LAST) state_d = S_WAIT_FRAMES;
            end
            S_WAIT_FRAMES: begin
                if (vs_rise) begin
                    if (frm_cnt_q == FRM_LAST) state_d = S_BL_RAMP;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = S_FAULT;
                end
            end
            S_BL_RAMP: begin
                // Exit is checked before the step so BL_MAX = 0 leaves immediately.
                if (duty_q == BL_MAX) begin
                    state_d = S_RUN;
                end else if (vs_rise) begin
                    duty_d = sat_add(duty_q, RAMP_INC);
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = S_FAULT;
                end
            end
            S_RUN: begin
                if (id_valid && (id_map != id_q)) begin
                    id_d    = id_map;
                    unsup_d = ~id_ok;
                    duty_d  = 8'd0;
                    state_d = S_DRV_RESET;
                end
            end
            S_FAULT: begin
                duty_d = 8'd0;
                if (idv_rise) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_FAULT) duty_d = 8'd0;

        state_chg = (state_d != state_q);
        rst_cnt_d = '0;
        frm_cnt_d = '0;
        to_cnt_d  = '0;
        if (!state_chg) begin
            if (state_q == S_DRV_RESET) rst_cnt_d = rst_cnt_q + 1'b1;
            frm_cnt_d = (state_q == S_WAIT_FRAMES && vs_rise) ? frm_cnt_q + 1'b1 : frm_cnt_q;
            if ((state_q == S_WAIT_FRAMES || state_q == S_BL_RAMP) && !vs_rise)
                to_cnt_d = to_cnt_q + 24'd1;
        end
    end

    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            id_q        <= 16'd0;
            unsup_q     <= 1'b0;
            duty_q      <= 8'd0;
            rst_cnt_q   <= '0;
            frm_cnt_q   <= '0;
            to_cnt_q    <= 24'd0;
            vs_d_q      <= 1'b0;
            idv_d_q     <= 1'b0;
            pwm_cnt_q   <= 8'd0;
            bl_pwm_q    <= 1'b0;
            drv_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            unsup_q     <= unsup_d;
            duty_q      <= duty_d;
            rst_cnt_q   <= rst_cnt_d;
            frm_cnt_q   <= frm_cnt_d;
            to_cnt_q    <= to_cnt_d;
            vs_d_q      <= lcd_vs;
            idv_d_q     <= id_valid;
            pwm_cnt_q   <= pwm_cnt_q + 8'd1;
            bl_pwm_q    <= (pwm_cnt_q < duty_q);
            // Outputs follow the state being entered so they change on the transition edge.
            drv_rst_n_q <= (state_d == S_WAIT_FRAMES) || (state_d == S_BL_RAMP) || (state_d == S_RUN);
            ready_q     <= (state_d == S_RUN);
            fault_q     <= (state_d == S_FAULT);
        end
    end

    assign ID_lcd    = id_q;
    assign id_unsup  = unsup_q;
    assign drv_rst_n = drv_rst_n_q;
    assign bl_pwm    = bl_pwm_q;
    assign ready     = ready_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_lcd_power_seq.sv
// Bench for lcd_power_seq: directed sequence scenarios plus randomized ID/vsync/reset traffic,
// all checked every cycle against a behavioural model of the sequencing rules.
module tb_lcd_power_seq;

    localparam int          RSTC   = 4;
    localparam int          SETTLE = 2;
    localparam logic [7:0]  BLM    = 8'd32;
    localparam logic [7:0]  BLS    = 8'd10;
    localparam logic [23:0] TO     = 24'd100;

    localparam int M_IDLE = 0, M_DRV = 1, M_WAIT = 2, M_RAMP = 3, M_RUN = 4, M_FAULT = 5;

    logic        lcd_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [15:0] id_raw    = 16'd0;
    logic        id_valid  = 1'b0;
    logic        lcd_vs    = 1'b0;
    logic [15:0] ID_lcd;
    logic        drv_rst_n, bl_pwm, ready, fault, id_unsup;

    lcd_power_seq #(
        .RST_CYCLES(RSTC), .SETTLE_FRAMES(SETTLE), .BL_MAX(BLM), .BL_STEP(BLS), .TIMEOUT(TO)
    ) dut (
        .lcd_clk(lcd_clk), .sys_rst_n(sys_rst_n), .id_raw(id_raw), .id_valid(id_valid),
        .lcd_vs(lcd_vs), .ID_lcd(ID_lcd), .drv_rst_n(drv_rst_n), .bl_pwm(bl_pwm),
        .ready(ready), .fault(fault), .id_unsup(id_unsup)
    );

    always #5 lcd_clk = ~lcd_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge lcd_clk);
            #1;
        end
    endtask

    // Behavioural model: phase, time spent in phase, frames seen, duty as plain integers.
    int m_phase, m_id, m_unsup, m_duty, m_pwm, m_blpwm, m_vsprev, m_ivprev, m_cnt, m_frames, m_to;
    int c_rst = 0, c_iv = 0, c_raw = 0, c_vs = 0;
    int duty_hist[$];

    function automatic bit supported(input int r);
        return (r == 0) || (r == 1) || (r == 2) || (r == 5);
    endfunction

    function automatic int ramp_next(input int d);
`ifdef LCD_SEQ_BL_RAMP_EN
        return (d + int'(BLS) > int'(BLM)) ? int'(BLM) : d + int'(BLS);
`else
        return int'(BLM) + 0 * d;
`endif
    endfunction

    task automatic model_reset();
        m_phase = M_IDLE; m_id = 0; m_unsup = 0; m_duty = 0; m_pwm = 0; m_blpwm = 0;
        m_vsprev = 0; m_ivprev = 0; m_cnt = 0; m_frames = 0; m_to = 0;
    endtask

    task automatic model_step();
        int  nxt, mapped, old_duty;
        bit  vsr, ivr;
        vsr      = c_vs && !m_vsprev;
        ivr      = c_iv && !m_ivprev;
        mapped   = supported(c_raw) ? c_raw : 0;
        nxt      = m_phase;
        old_duty = m_duty;
        m_blpwm  = (m_pwm < m_duty);
        m_pwm    = (m_pwm + 1) % 256;
        case (m_phase)
            M_IDLE: if (c_iv) begin
                m_id = mapped; m_unsup = !supported(c_raw); nxt = M_DRV;
            end
            M_DRV: if (m_cnt + 1 == RSTC) nxt = M_WAIT;
            M_WAIT: begin
                if (vsr) begin
                    m_frames++;
                    if (m_frames == SETTLE) nxt = M_RAMP;
                end else if (m_to + 1 == int'(TO)) nxt = M_FAULT;
            end
            M_RAMP: begin
                if (m_duty == int'(BLM)) nxt = M_RUN;
                else if (vsr) m_duty = ramp_next(m_duty);
                else if (m_to + 1 == int'(TO)) nxt = M_FAULT;
            end
            M_RUN: if (c_iv && mapped != m_id) begin
                m_id = mapped; m_unsup = !supported(c_raw); m_duty = 0; nxt = M_DRV;
            end
            default: if (ivr) nxt = M_IDLE;
        endcase
        if (nxt == M_FAULT) m_duty = 0;
        if (m_duty != old_duty && m_duty != 0) duty_hist.push_back(m_duty);
        if (nxt != m_phase) begin
            m_cnt = 0; m_frames = 0; m_to = 0;
        end else begin
            m_cnt++;
            m_to = vsr ? 0 : m_to + 1;
        end
        m_phase  = nxt;
        m_vsprev = c_vs;
        m_ivprev = c_iv;
    endtask

    // Per-cycle compare; inputs only change just after a rising edge, so the values seen
    // at one falling edge are exactly what the following rising edge samples.
    initial begin
        model_reset();
        forever begin
            @(negedge lcd_clk);
            if (c_rst == 0 || !sys_rst_n) model_reset();
            else model_step();
            chk("ID_lcd", ID_lcd, m_id);
            chk("id_unsup", id_unsup, m_unsup);
            chk("drv_rst_n", drv_rst_n, (m_phase == M_WAIT || m_phase == M_RAMP || m_phase == M_RUN));
            chk("ready", ready, m_phase == M_RUN);
            chk("fault", fault, m_phase == M_FAULT);
            chk("bl_pwm", bl_pwm, m_blpwm);
            c_rst = sys_rst_n; c_iv = id_valid; c_raw = id_raw; c_vs = lcd_vs;
        end
    end

    // Vsync source: 3-cycle pulses every vs_period cycles; period 0 holds it low.
    int vs_period = 50;
    int vs_ctr    = 0;
    bit vs_rand   = 0;
    initial forever begin
        @(posedge lcd_clk);
        #1;
        if (vs_period == 0) begin
            lcd_vs = 1'b0;
            vs_ctr = 0;
        end else begin
            vs_ctr++;
            if (vs_ctr >= vs_period) begin
                vs_ctr = 0;
                if (vs_rand) vs_period = ($urandom_range(0, 11) == 0) ? 130 : int'($urandom_range(20, 70));
            end
            lcd_vs = (vs_ctr < 3);
        end
    end

    task automatic wait_ready(input string name, input int budget);
        int n = 0;
        while (ready !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk(name, ready, 1'b1);
    endtask

    task automatic check_hist(input string name);
        int exp[$];
`ifdef LCD_SEQ_BL_RAMP_EN
        exp = '{10, 20, 30, 32};
`else
        exp = '{32};
`endif
        chk({name, "_len"}, duty_hist.size(), exp.size());
        for (int i = 0; i < exp.size() && i < duty_hist.size(); i++)
            chk({name, "_step"}, duty_hist[i], exp[i]);
    endtask

    task automatic count_rst_low(input string name);
        int n = 0;
        while (drv_rst_n == 1'b0 && n < 20) begin
            tick();
            n++;
        end
        chk(name, n, RSTC);
    endtask

    initial begin
        int n, r;
        #1;
        chk("reset_state", {ID_lcd, drv_rst_n, bl_pwm, ready, fault, id_unsup}, 0);
        tick(3);
        sys_rst_n = 1'b1;
        tick(2);

        // Power-up with ID 1.
        duty_hist.delete();
        id_raw = 16'd1; id_valid = 1'b1;
        tick();
        chk("pu_id_latched", ID_lcd, 16'd1);
        chk("pu_drv_low", drv_rst_n, 1'b0);
        count_rst_low("pu_rst_len");
        wait_ready("pu_ready", 1000);
        check_hist("pu_duty");
        chk("pu_model_duty", m_duty, BLM);
        n = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            n += bl_pwm;
        end
        chk("pu_pwm_high_count", n, 32);

        // Unsupported ID.
        id_raw = 16'd3;
        tick();
        chk("unsup_id", ID_lcd, 16'd0);
        chk("unsup_flag", id_unsup, 1'b1);
        chk("unsup_ready_drop", ready, 1'b0);
        wait_ready("unsup_ready", 1000);
        chk("unsup_flag_kept", id_unsup, 1'b1);

        // Back to 1, then change 1 -> 2 in RUN.
        id_raw = 16'd1;
        tick();
        chk("sup_clears_flag", id_unsup, 1'b0);
        wait_ready("id1_ready", 1000);
        duty_hist.delete();
        id_raw = 16'd2;
        tick();
        chk("chg_ready_drop", ready, 1'b0);
        chk("chg_id", ID_lcd, 16'd2);
        chk("chg_drv_low", drv_rst_n, 1'b0);
        count_rst_low("chg_rst_len");
        wait_ready("chg_ready", 1000);
        check_hist("chg_duty");

        // Vsync stall -> fault, then recovery via id_valid rising edge.
        vs_period = 0;
        id_raw = 16'd5;
        tick();
        n = 0;
        while (drv_rst_n == 1'b0 && n < 20) begin
            tick();
            n++;
        end
        n = 0;
        while (fault == 1'b0 && n < 300) begin
            tick();
            n++;
        end
        chk("fault_latency", n, 100);
        chk("fault_drv_low", drv_rst_n, 1'b0);
        chk("fault_pwm_low", bl_pwm, 1'b0);
        id_valid = 1'b0;
        tick(3);
        chk("fault_hold", fault, 1'b1);
        vs_period = 50;
        id_valid = 1'b1;
        wait_ready("fault_recover", 1200);
        chk("fault_recover_id", ID_lcd, 16'd5);

        // Asynchronous reset in the middle of the ramp.
        id_raw = 16'd1;
        n = 0;
`ifdef LCD_SEQ_BL_RAMP_EN
        while (m_duty != 20 && n < 1000) begin
`else
        while (m_phase != M_RAMP && n < 1000) begin
`endif
            tick();
            n++;
        end
        chk("ramp_reached", n < 1000, 1'b1);
        sys_rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {ID_lcd, drv_rst_n, bl_pwm, ready, fault, id_unsup}, 0);
        tick(3);
        sys_rst_n = 1'b1;
        duty_hist.delete();
        wait_ready("replay_ready", 1200);
        chk("replay_id", ID_lcd, 16'd1);
        check_hist("replay_duty");

        // id_valid low in RUN is ignored.
        id_valid = 1'b0;
        id_raw = 16'd2;
        tick(10);
        chk("novalid_ready", ready, 1'b1);
        chk("novalid_id", ID_lcd, 16'd1);
        id_raw = 16'd1;
        id_valid = 1'b1;
        tick();

        // Randomized traffic against the model.
        vs_rand = 1;
        for (int i = 0; i < 5000; i++) begin
            r = $urandom_range(0, 999);
            if (r < 3) id_raw = 16'($urandom_range(0, 7));
            else if (r < 7) id_valid = ~id_valid;
            else if (r == 7) begin
                sys_rst_n = 1'b0;
                tick(2);
                sys_rst_n = 1'b1;
            end
            tick();
        end
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
